col_pe: RTL and testbench

Vertical (column-wise) stage of the separable 7×7 convolution. It consumes the row-convolved pixel stream from the row processing element and stores the previous six rows in line buffers. Once six prior rows are held, it produces one 7-tap vertical convolution result for every accepted pixel, normalised and clamped to 8 bits. It drives the downstream sink with the same vld/rdy/eor/eof stream protocol.

---
 rtl/col_pe.sv | 183 ++++++++++++++++++
 tb/tb_col_pe.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/col_pe.sv
// col_pe: vertical 7-tap stage of the separable 7x7 convolution with six line buffers.
// Define COL_PE_ROUND_EN to round half up before normalisation (default: truncate).
module col_pe #(
  parameter int DATA_W = 8,
  parameter int MAX_W  = 64,
  parameter logic signed [4:0] WEIGHT_0 = 5'sd1,
  parameter logic signed [4:0] WEIGHT_1 = -5'sd2,
  parameter logic signed [4:0] WEIGHT_2 = 5'sd3,
  parameter logic signed [4:0] WEIGHT_3 = -5'sd4,
  parameter logic signed [4:0] WEIGHT_4 = 5'sd5,
  parameter logic signed [4:0] WEIGHT_5 = -5'sd6,
  parameter logic signed [4:0] WEIGHT_6 = 5'sd7
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_vld,
  input  logic              i_eor,
  input  logic              i_eof,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_rdy,
  input  logic              i_rdy,
  output logic              o_vld,
  output logic              o_eor,
  output logic              o_eof,
  output logic [DATA_W-1:0] o_data,
  output logic              o_err
);

  localparam int COL_W = $clog2(MAX_W);
  localparam int WID_W = COL_W + 1;
  localparam int ACC_W = 19;
  localparam int NTAP  = 7;
  localparam int NROW  = 6;
  localparam int WSUM  = int'(WEIGHT_0) + int'(WEIGHT_1) + int'(WEIGHT_2) + int'(WEIGHT_3)
                       + int'(WEIGHT_4) + int'(WEIGHT_5) + int'(WEIGHT_6);
  localparam int NORM_SUM   = (WSUM < 0) ? -WSUM : WSUM;
  localparam int NORM_COEFF = (NORM_SUM > 0) ? $clog2(NORM_SUM) : 0;
  localparam logic [DATA_W-1:0] PIX_MAX = '1;
  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(MAX_W - 1);

`ifdef COL_PE_ROUND_EN
  function automatic logic signed [ACC_W-1:0] rnd_ofs(input int coeff);
    if (coeff > 0) rnd_ofs = 19'sd1 <<< (coeff - 1);
    else rnd_ofs = 19'sd0;
  endfunction
  localparam logic signed [ACC_W-1:0] RND_OFS = rnd_ofs(NORM_COEFF);
`else
  localparam logic signed [ACC_W-1:0] RND_OFS = 19'sd0;
`endif

  function automatic logic signed [ACC_W-1:0] tap_w(input int k);
    case (k)
      0: tap_w = ACC_W'(WEIGHT_0);
      1: tap_w = ACC_W'(WEIGHT_1);
      2: tap_w = ACC_W'(WEIGHT_2);
      3: tap_w = ACC_W'(WEIGHT_3);
      4: tap_w = ACC_W'(WEIGHT_4);
      5: tap_w = ACC_W'(WEIGHT_5);
      6: tap_w = ACC_W'(WEIGHT_6);
      default: tap_w = 19'sd0;
    endcase
  endfunction

  logic [DATA_W-1:0] lb_q [NROW][MAX_W];
  logic [COL_W-1:0]  col_q;
  logic [2:0]        rows_q;
  logic [WID_W-1:0]  width_q;
  logic              err_q;

  logic [DATA_W-1:0]        s1_pix_q [NTAP];
  logic                     s1_vld_q, s1_eor_q, s1_eof_q;
  logic signed [ACC_W-1:0]  s2_sum_q;
  logic                     s2_vld_q, s2_eor_q, s2_eof_q;
  logic [DATA_W-1:0]        out_data_q;
  logic                     out_vld_q, out_eor_q, out_eof_q;

  logic                     pipe_en_s, accept_s, stream_s;
  logic                     row_end_s, forced_s, eof_s, mismatch_s;
  logic [WID_W-1:0]         col_plus1_s;
  logic signed [ACC_W-1:0]  sum_s, norm_s;
  logic [DATA_W-1:0]        clamp_s;

  assign pipe_en_s   = !out_vld_q || i_rdy;
  assign o_rdy       = pipe_en_s && !i_rst;
  assign accept_s    = i_vld && o_rdy;
  assign stream_s    = (rows_q == 3'd6);
  assign forced_s    = !i_eor && (col_q == COL_LAST);
  assign row_end_s   = i_eor || (col_q == COL_LAST);
  assign eof_s       = i_eor && i_eof;
  assign col_plus1_s = {1'b0, col_q} + {{COL_W{1'b0}}, 1'b1};
  assign mismatch_s  = (width_q != '0) && (col_plus1_s != width_q);

  // Line buffers shift one row down at the accepted column; contents survive reset.
  always_ff @(posedge i_clk) begin
    if (accept_s) begin
      lb_q[0][col_q] <= i_data;
      for (int k = 1; k < NROW; k++) lb_q[k][col_q] <= lb_q[k-1][col_q];
    end
  end

  // Column, row, width and sticky error tracking; all change only on accept.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      col_q   <= '0;
      rows_q  <= 3'd0;
      width_q <= '0;
      err_q   <= 1'b0;
    end else if (accept_s) begin
      if (row_end_s) begin
        col_q <= '0;
        if (forced_s || mismatch_s) err_q <= 1'b1;
        if (eof_s) begin
          rows_q  <= 3'd0;
          width_q <= '0;
        end else begin
          if (rows_q != 3'd6) rows_q <= rows_q + 3'd1;
          if (width_q == '0) width_q <= col_plus1_s;
        end
      end else begin
        col_q <= col_q + {{(COL_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Seven-tap dot product of the registered column vector.
  always_comb begin
    sum_s = 19'sd0;
    for (int k = 0; k < NTAP; k++) begin
      sum_s = sum_s + $signed(ACC_W'(s1_pix_q[k])) * tap_w(k);
    end
  end

  // Normalise and clamp the registered sum to the pixel range.
  always_comb begin
    norm_s = (s2_sum_q + RND_OFS) >>> NORM_COEFF;
    if (norm_s[ACC_W-1]) begin
      clamp_s = '0;
    end else if (norm_s > $signed({{(ACC_W-DATA_W){1'b0}}, PIX_MAX})) begin
      clamp_s = PIX_MAX;
    end else begin
      clamp_s = norm_s[DATA_W-1:0];
    end
  end

  // Three-stage pipeline; the whole pipe freezes while the output is stalled.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < NTAP; k++) s1_pix_q[k] <= '0;
      s1_vld_q   <= 1'b0;
      s1_eor_q   <= 1'b0;
      s1_eof_q   <= 1'b0;
      s2_sum_q   <= 19'sd0;
      s2_vld_q   <= 1'b0;
      s2_eor_q   <= 1'b0;
      s2_eof_q   <= 1'b0;
      out_data_q <= '0;
      out_vld_q  <= 1'b0;
      out_eor_q  <= 1'b0;
      out_eof_q  <= 1'b0;
    end else if (pipe_en_s) begin
      s1_pix_q[0] <= i_data;
      for (int k = 1; k < NTAP; k++) s1_pix_q[k] <= lb_q[k-1][col_q];
      s1_vld_q   <= accept_s && stream_s;
      s1_eor_q   <= accept_s && stream_s && row_end_s;
      s1_eof_q   <= accept_s && stream_s && eof_s;
      s2_sum_q   <= sum_s;
      s2_vld_q   <= s1_vld_q;
      s2_eor_q   <= s1_eor_q;
      s2_eof_q   <= s1_eof_q;
      out_data_q <= clamp_s;
      out_vld_q  <= s2_vld_q;
      out_eor_q  <= s2_eor_q;
      out_eof_q  <= s2_eof_q;
    end
  end

  assign o_vld  = out_vld_q;
  assign o_eor  = out_eor_q;
  assign o_eof  = out_eof_q;
  assign o_data = out_data_q;
  assign o_err  = err_q;

endmodule

// File: tb/tb_col_pe.sv
// Scoreboard bench for col_pe: the driver queues hand-computed outputs, a monitor checks them.
`timescale 1ns/1ps
module tb_col_pe;
  logic       i_clk = 1'b0, i_rst = 1'b1, i_vld = 1'b0, i_eor = 1'b0, i_eof = 1'b0, i_rdy = 1'b1;
  logic [7:0] i_data = 8'd0;
  logic [7:0] o_data;
  logic       o_rdy, o_vld, o_eor, o_eof, o_err;

  typedef struct {logic [7:0] d; logic eor; logic eof; int cyc; bit lat;} exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0, failures = 0, cyc = 0, tmode = 0;

`ifdef COL_PE_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  col_pe dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_vld(i_vld), .i_eor(i_eor), .i_eof(i_eof),
    .i_data(i_data), .o_rdy(o_rdy), .i_rdy(i_rdy), .o_vld(o_vld), .o_eor(o_eor),
    .o_eof(o_eof), .o_data(o_data), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Input pixel for row r, column c of the current test pattern.
  function automatic logic [7:0] px(input int r, input int c);
    case (tmode)
      0: px = 8'd100;
      1: px = (r == 0 && c == 2) ? 8'd255 : 8'd0;
      2: px = (r == 1 && c == 2) ? 8'd255 : 8'd0;
      3: px = (r == 6 && c == 0) ? 8'd3 : 8'd0;
      4: px = 8'd50;
      default: px = 8'd0;
    endcase
  endfunction

  // Hand-computed output: taps sum to 4, shift by 2; 255*7=1785>>2 clamps; 255*-6 clamps to 0.
  function automatic logic [7:0] ex(input int c);
    case (tmode)
      0: ex = 8'd100;
      1: ex = (c == 2) ? 8'd255 : 8'd0;
      2: ex = 8'd0;
      3: ex = (c == 0 && RND) ? 8'd1 : 8'd0;
      4: ex = 8'd50;
      default: ex = 8'd0;
    endcase
  endfunction

  // Monitor: every transferred output pixel is matched against the scoreboard.
  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (!o_vld) begin
        chk("idle_flags", int'({o_eor, o_eof}), 0);
      end else if (i_rdy) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output actual=data %0d expected=no output", o_data);
        end else begin
          mon_e = sb.pop_front();
          chk("out_data", o_data, mon_e.d);
          chk("out_eor", o_eor, mon_e.eor);
          chk("out_eof", o_eof, mon_e.eof);
          if (mon_e.lat) chk("latency", cyc - mon_e.cyc, 3);
        end
      end
    end
  end

  task automatic send_px(input logic [7:0] d, input logic eor, input logic eof, input bit exp_v,
                         input logic [7:0] ed, input logic ee, input logic ef, input bit lat);
    bit done;
    done = 1'b0;
    i_vld = 1'b1; i_data = d; i_eor = eor; i_eof = eof;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge i_clk);
      if (o_rdy) begin
        done = 1'b1;
        if (exp_v) sb.push_back('{ed, ee, ef, cyc, lat});
      end
      @(posedge i_clk);
      #1;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=o_rdy low expected=accept within 200 cycles");
    end
    i_vld = 1'b0; i_eor = 1'b0; i_eof = 1'b0;
  endtask

  task automatic stall5();
    logic [7:0] hd;
    i_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      if (i == 0) hd = o_data;
      else chk("stall_data", o_data, hd);
      chk("stall_vld", o_vld, 1);
      chk("stall_rdy", o_rdy, 0);
      @(posedge i_clk);
      #1;
    end
    i_rdy = 1'b1;
  endtask

  task automatic send_frame(input int nrows, input int ncols, input bit eof_last, input bit lat,
                            input int stall_r, input int stall_c);
    logic eor, eof;
    for (int r = 0; r < nrows; r++) begin
      for (int c = 0; c < ncols; c++) begin
        eor = (c == ncols - 1);
        eof = eof_last && (r == nrows - 1) && eor;
        send_px(px(r, c), eor, eof, r >= 6, ex(c), eor, eof, lat);
        if (r == stall_r && c == stall_c) stall5();
      end
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 100 && sb.size() != 0; n++) @(posedge i_clk);
    repeat (4) @(posedge i_clk);
    #1;
    chk("drain_empty", sb.size(), 0);
  endtask

  task automatic do_reset();
    i_rst = 1'b1; i_vld = 1'b0;
    sb.delete();
    @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_vld", o_vld, 0);
    chk("rst_rdy", o_rdy, 0);
    chk("rst_data", o_data, 0);
    chk("rst_eor", o_eor, 0);
    chk("rst_eof", o_eof, 0);
    chk("rst_err", o_err, 0);
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
  endtask

  initial begin
    do_reset();

    tmode = 0; send_frame(7, 8, 1'b1, 1'b1, -1, -1); drain();
    tmode = 1; send_frame(7, 8, 1'b1, 1'b1, -1, -1); drain();
    tmode = 2; send_frame(7, 8, 1'b1, 1'b1, -1, -1); drain();
    tmode = 3; send_frame(7, 8, 1'b1, 1'b1, -1, -1); drain();
    tmode = 0; send_frame(7, 8, 1'b1, 1'b0, 6, 3); drain();

    // Reset in the middle of row 8, then a fresh frame must refill six rows.
    tmode = 0; send_frame(8, 8, 1'b0, 1'b1, -1, -1);
    for (int c = 0; c < 3; c++) send_px(8'd100, 1'b0, 1'b0, 1'b1, 8'd100, 1'b0, 1'b0, 1'b1);
    do_reset();
    tmode = 4; send_frame(7, 8, 1'b1, 1'b1, -1, -1); drain();

    // Short second row flags a sticky geometry error.
    do_reset();
    for (int c = 0; c < 8; c++) send_px(8'd100, c == 7, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    @(negedge i_clk); chk("err_clean", o_err, 0);
    @(posedge i_clk); #1;
    for (int c = 0; c < 6; c++) send_px(8'd100, c == 5, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    @(negedge i_clk); chk("err_set", o_err, 1);
    repeat (5) @(posedge i_clk);
    @(negedge i_clk); chk("err_sticky", o_err, 1);
    @(posedge i_clk); #1;
    do_reset();

    // Full-width rows, then a row with no eor that is forced to end at column 63.
    tmode = 0; send_frame(6, 64, 1'b0, 1'b1, -1, -1);
    @(negedge i_clk); chk("err_full_width", o_err, 0);
    @(posedge i_clk); #1;
    for (int c = 0; c < 64; c++) send_px(8'd100, 1'b0, 1'b0, 1'b1, 8'd100, c == 63, 1'b0, 1'b1);
    drain();
    chk("err_forced", o_err, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout actual=still running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

endmodule
